// File: rtl/bias_shift_rq_if.sv
// rtl/bias_shift_rq_if.sv - input/output beat handshake and lane data bundle for bias_shift_rq
// The slave modport is the requantiser's view; the master modport is the view of its neighbours.
interface bias_shift_rq_if #(
  parameter int LANES     = 4,
  parameter int DATA_BITS = 48,
  parameter int OUT_BITS  = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_BITS-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*OUT_BITS-1:0]  out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/bias_shift_rq.sv
// rtl/bias_shift_rq.sv - multi-lane requantiser: arithmetic right shift, optional rounding and saturation
// Stage 1 adds the rounding bias and shifts; stage 2 saturates or wraps to OUT_BITS.
module bias_shift_rq #(
  parameter int LANES     = 4,
  parameter int DATA_BITS = 48,
  parameter int OUT_BITS  = 16,
  parameter int SHIFT_W   = 5,
  parameter int MIN_SHIFT = 5,
  parameter int MAX_SHIFT = 25
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_we,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_round,
  input  logic               cfg_sat,
  bias_shift_rq_if.slave     bus,
  output logic               err_shift,
  input  logic               err_clr
);

  // One extra MSB keeps the rounding add from overflowing at full-scale inputs.
  localparam int WB = DATA_BITS + 1;
  typedef logic signed [WB-1:0] wide_t;

  localparam wide_t OUT_MAX = wide_t'({(OUT_BITS-1){1'b1}});
  localparam wide_t OUT_MIN = ~OUT_MAX;

  logic [SHIFT_W-1:0] shift_q;
  logic               round_q;
  logic               sat_q;

  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic adv1, adv2, accept;

  logic  shift_ok;
  wide_t bias;
  wide_t s1_d [LANES];
  wide_t s1_q [LANES];
  logic  sat1_q;

  logic [LANES*OUT_BITS-1:0] out_d, out_q;
  logic                      err_d, err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= SHIFT_W'(MIN_SHIFT);
      round_q <= 1'b0;
      sat_q   <= 1'b0;
    end else if (cfg_we) begin
      shift_q <= cfg_shift;
      round_q <= cfg_round;
      sat_q   <= cfg_sat;
    end
  end

  assign adv2         = !v2_q || bus.out_ready;
  assign adv1         = !v1_q || adv2;
  assign bus.in_ready = adv1;
  assign accept       = bus.in_valid && adv1;

  assign shift_ok = (shift_q >= SHIFT_W'(MIN_SHIFT)) && (shift_q <= SHIFT_W'(MAX_SHIFT));
  assign bias     = (round_q && shift_ok) ? (wide_t'(1) << (shift_q - SHIFT_W'(1))) : '0;

  // An illegal shift still produces a beat, forced to zero so it flows through unchanged.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      s1_d[i] = '0;
      if (shift_ok) begin
        s1_d[i] = (wide_t'($signed(bus.in_data[i*DATA_BITS +: DATA_BITS])) + bias) >>> shift_q;
      end
    end
  end

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    if (adv1) v1_d = bus.in_valid;
    if (adv2) v2_d = v1_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q   <= 1'b0;
      sat1_q <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_q[i] <= '0;
    end else begin
      v1_q <= v1_d;
      if (accept) begin
        s1_q   <= s1_d;
        sat1_q <= sat_q;
      end
    end
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sat1_q && (s1_q[i] > OUT_MAX)) begin
        out_d[i*OUT_BITS +: OUT_BITS] = OUT_MAX[OUT_BITS-1:0];
      end else if (sat1_q && (s1_q[i] < OUT_MIN)) begin
        out_d[i*OUT_BITS +: OUT_BITS] = OUT_MIN[OUT_BITS-1:0];
      end else begin
        out_d[i*OUT_BITS +: OUT_BITS] = s1_q[i][OUT_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_q  <= 1'b0;
      out_q <= '0;
    end else begin
      v2_q <= v2_d;
      if (v1_q && adv2) out_q <= out_d;
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.out_data  = out_q;

  // Clear wins over a same-cycle illegal-shift acceptance.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end else if (accept && !shift_ok) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_shift = err_q;

endmodule
